ex_mdu: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit next to the EX stage. Executes MULT(U), MADD(U), MSUB(U), DIV(U) under a start/cancel handshake.

---
 rtl/ex_mdu_pkg.sv | 42 ++++
 rtl/ex_mdu_div_core.sv | 51 +++++
 rtl/ex_mdu.sv | 163 ++++++++++++++++
 tb/tb_ex_mdu.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the EX-stage multiply/divide unit.
package ex_mdu_pkg;

  localparam int unsigned MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_MADD  = 3'b010,
    OP_MADDU = 3'b011,
    OP_MSUB  = 3'b100,
    OP_MSUBU = 3'b101,
    OP_DIV   = 3'b110,
    OP_DIVU  = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_ACC,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic op_signed(logic [MDU_OP_W-1:0] op);
    return !(op == OP_MULTU || op == OP_MADDU || op == OP_MSUBU || op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(logic [MDU_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_sub(logic [MDU_OP_W-1:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic op_is_acc(logic [MDU_OP_W-1:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || op_is_sub(op);
  endfunction

endpackage

// File: rtl/ex_mdu_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per step, WIDTH steps.
module ex_mdu_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             last_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   shift_c;
  logic [WIDTH:0]   diff_c;

  // The dividend shifts out of the quotient register as quotient bits shift in.
  assign shift_c = {rem_o, quo_o[WIDTH-1]};
  assign diff_c  = shift_c - {1'b0, dsr_q};
  assign last_c  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      quo_o <= '0;
      rem_o <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      quo_o <= dividend_i;
      rem_o <= '0;
      dsr_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      if (!diff_c[WIDTH]) begin
        rem_o <= diff_c[WIDTH-1:0];
        quo_o <= {quo_o[WIDTH-2:0], 1'b1};
      end else begin
        rem_o <= shift_c[WIDTH-1:0];
        quo_o <= {quo_o[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Multi-cycle MULT/MADD/MSUB/DIV unit beside EX with start/cancel handshake.
// Optional MDU_EARLY_OUT_EN: divides with |a|<|b| finish without iterating.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                cancel_i,
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic [2*WIDTH-1:0]  hilo_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WIDTH-1:0]    hi_o,
  output logic [WIDTH-1:0]    lo_o,
  output logic                div0_o
);

  localparam int unsigned DW = 2 * WIDTH;

  mdu_state_e state_q, state_d;

  logic [MDU_OP_W-1:0] op_q;
  logic [WIDTH-1:0]    a_q, a_mag_q, b_mag_q;
  logic [DW-1:0]       hilo_q, prod_q;
  logic                neg_q, a_neg_q, div0_q, early_q;

  logic             accept_c, a_neg_c, b_neg_c, early_c, div_step_c, div_last_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, div_quo, div_rem, quo_c, rem_c;
  logic [DW-1:0]    prod_mag_c, prod_c, acc_c;

  assign accept_c = start_i && !cancel_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign a_neg_c  = op_signed(op_i) && a_i[WIDTH-1];
  assign b_neg_c  = op_signed(op_i) && b_i[WIDTH-1];
  assign a_mag_c  = a_neg_c ? WIDTH'(-a_i) : a_i;
  assign b_mag_c  = b_neg_c ? WIDTH'(-b_i) : b_i;

`ifdef MDU_EARLY_OUT_EN
  assign early_c = op_is_div(op_i) && (b_i != '0) && (a_mag_c < b_mag_c);
`else
  assign early_c = 1'b0;
`endif

  // Magnitudes multiply unsigned; the sign is reapplied on the full 2W product.
  assign prod_mag_c = DW'(a_mag_q) * DW'(b_mag_q);
  assign prod_c     = neg_q ? DW'(-prod_mag_c) : prod_mag_c;
  assign acc_c      = op_is_sub(op_q) ? (hilo_q - prod_q) : (hilo_q + prod_q);
  assign quo_c      = neg_q ? WIDTH'(-div_quo) : div_quo;
  assign rem_c      = a_neg_q ? WIDTH'(-div_rem) : div_rem;
  assign div_step_c = (state_q == ST_DIV) && !cancel_i;

  ex_mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept_c),
    .step_i     (div_step_c),
    .dividend_i (a_mag_c),
    .divisor_i  (b_mag_c),
    .quo_o      (div_quo),
    .rem_o      (div_rem),
    .last_c     (div_last_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          if (!op_is_div(op_i))            state_d = ST_MUL;
          else if (b_i == '0 || early_c)   state_d = ST_FIX;
          else                             state_d = ST_DIV;
        end
      end
      ST_MUL:  state_d = op_is_acc(op_q) ? ST_ACC : ST_DONE;
      ST_ACC:  state_d = ST_DONE;
      ST_DIV:  if (div_last_c) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (cancel_i) state_d = ST_IDLE;
  end

  // Operand capture at accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q    <= '0;
      a_q     <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      hilo_q  <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      early_q <= 1'b0;
    end else if (accept_c) begin
      op_q    <= op_i;
      a_q     <= a_i;
      a_mag_q <= a_mag_c;
      b_mag_q <= b_mag_c;
      hilo_q  <= hilo_i;
      neg_q   <= a_neg_c ^ b_neg_c;
      a_neg_q <= a_neg_c;
      div0_q  <= op_is_div(op_i) && (b_i == '0);
      early_q <= early_c;
    end else if (state_q == ST_MUL) begin
      prod_q  <= prod_c;
    end
  end

  // Result registers only change on the cycle that leads into DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      div0_o <= 1'b0;
    end else begin
      busy_o <= (state_d inside {ST_MUL, ST_ACC, ST_DIV, ST_FIX});
      done_o <= (state_d == ST_DONE);
      if (!cancel_i) begin
        case (state_q)
          ST_MUL: if (!op_is_acc(op_q)) begin
            {hi_o, lo_o} <= prod_c;
            div0_o       <= 1'b0;
          end
          ST_ACC: begin
            {hi_o, lo_o} <= acc_c;
            div0_o       <= 1'b0;
          end
          ST_FIX: begin
            if (div0_q) begin
              lo_o   <= '1;
              hi_o   <= a_q;
              div0_o <= 1'b1;
            end else if (early_q) begin
              lo_o   <= '0;
              hi_o   <= a_q;
              div0_o <= 1'b0;
            end else begin
              lo_o   <= quo_c;
              hi_o   <= rem_c;
              div0_o <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: expected results queued at start, popped at done_o.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int unsigned W = 32;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic             cancel_i;
  logic [2:0]       op_i;
  logic [W-1:0]     a_i;
  logic [W-1:0]     b_i;
  logic [2*W-1:0]   hilo_i;
  logic             busy_o;
  logic             done_o;
  logic [W-1:0]     hi_o;
  logic [W-1:0]     lo_o;
  logic             div0_o;

  ex_mdu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .cancel_i (cancel_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .hilo_i   (hilo_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .div0_o   (div0_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   checks   = 0;
  int   failures = 0;

  // Reference: 64-bit arithmetic on sign/zero-extended operands.
  function automatic exp_t model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                 logic [2*W-1:0] hilo);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = op[0] ? longint'({32'h0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'h0, b}) : longint'($signed(b));
    p  = 64'(sa * sb);
    e.div0 = 1'b0;
    case (op)
      3'b000, 3'b001: begin {e.hi, e.lo} = p;        e.lat = 2; end
      3'b010, 3'b011: begin {e.hi, e.lo} = hilo + p; e.lat = 3; end
      3'b100, 3'b101: begin {e.hi, e.lo} = hilo - p; e.lat = 3; end
      default: begin
        if (b == '0) begin
          e.lo = '1; e.hi = a; e.div0 = 1'b1; e.lat = 2;
        end else begin
          q = sa / sb;
          r = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
          e.lat = 34;
`ifdef MDU_EARLY_OUT_EN
          if ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb)) e.lat = 2;
`endif
        end
      end
    endcase
    return e;
  endfunction

  // Called just after a negedge; returns just after the negedge of cycle N+1.
  task automatic drive_start(input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [2*W-1:0] hilo);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; hilo_i = hilo;
    sb_q.push_back(model(op, a, b, hilo));
    @(negedge clk);
    start_i = 1'b0;
    op_i    = 3'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
    hilo_i  = {$urandom, $urandom};
  endtask

  task automatic wait_done(output int lat, output bit seen);
    lat = 1;
    while (!done_o && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    seen = done_o;
    if (!seen) begin
      cancel_i = 1'b1;
      @(negedge clk);
      cancel_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0; hilo_i = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", done_o); end
    checks++; if (hi_o !== '0)     begin failures++; $display("FAIL reset_hi got %h exp 0", hi_o); end
    checks++; if (lo_o !== '0)     begin failures++; $display("FAIL reset_lo got %h exp 0", lo_o); end
    checks++; if (div0_o !== 1'b0) begin failures++; $display("FAIL reset_div0 got %b exp 0", div0_o); end
    rst = 1'b1;
    @(negedge clk);
    last_exp = '{hi: '0, lo: '0, div0: 1'b0, lat: 0};
  endtask

  task automatic test_mul();
    logic [2:0]   ops [4] = '{OP_MULT, OP_MULTU, OP_MULT, OP_MULT};
    logic [W-1:0] av  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h0001_2345};
    logic [W-1:0] bv  [4] = '{32'h5, 32'hFFFFFFFF, 32'h80000000, 32'hFFFF_0F0F};
    exp_t e; int lat; bit seen;
    for (int i = 0; i < 4; i++) begin
      drive_start(ops[i], av[i], bv[i], {$urandom, $urandom});
      if (i == 0) begin
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL mul_busy_n1 got %b exp 1", busy_o); end
      end
      wait_done(lat, seen);
      e = sb_q.pop_front();
      if (i == 0) begin
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mul_busy_done got %b exp 0", busy_o); end
      end
      checks++;
      if (!seen || lat != e.lat) begin failures++; $display("FAIL mul_latency[%0d] got %0d exp %0d", i, lat, e.lat); end
      checks++;
      if ({hi_o, lo_o, div0_o} !== {e.hi, e.lo, e.div0}) begin
        failures++;
        $display("FAIL mul_result[%0d] got hi=%h lo=%h div0=%b exp hi=%h lo=%h div0=%b", i, hi_o, lo_o, div0_o, e.hi, e.lo, e.div0);
      end
      last_exp = e;
    end
  endtask

  task automatic test_acc();
    logic [2:0]     ops [4] = '{OP_MADDU, OP_MSUB, OP_MADD, OP_MSUBU};
    logic [W-1:0]   av  [4] = '{32'h2, 32'h2, 32'hFFFF_FFF0, 32'h8000_0001};
    logic [W-1:0]   bv  [4] = '{32'h3, 32'h3, 32'h0000_0100, 32'hFFFF_FFFF};
    logic [2*W-1:0] hv  [4] = '{64'h00000001_FFFFFFFF, 64'h00000001_FFFFFFFF,
                                64'h00000000_00000010, 64'h00000000_00000005};
    exp_t e; int lat; bit seen;
    for (int i = 0; i < 4; i++) begin
      drive_start(ops[i], av[i], bv[i], hv[i]);
      wait_done(lat, seen);
      e = sb_q.pop_front();
      checks++;
      if (!seen || lat != e.lat) begin failures++; $display("FAIL acc_latency[%0d] got %0d exp %0d", i, lat, e.lat); end
      checks++;
      if ({hi_o, lo_o, div0_o} !== {e.hi, e.lo, e.div0}) begin
        failures++;
        $display("FAIL acc_result[%0d] got hi=%h lo=%h div0=%b exp hi=%h lo=%h div0=%b", i, hi_o, lo_o, div0_o, e.hi, e.lo, e.div0);
      end
      last_exp = e;
    end
  endtask

  task automatic test_div();
    logic [2:0]   ops [7] = '{OP_DIV, OP_DIV, OP_DIVU, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
    logic [W-1:0] av  [7] = '{32'hFFFFFFF9, 32'h80000000, 32'h1234, 32'h3, 32'h64, 32'h8765_4321, 32'hFFFF_FFFF};
    logic [W-1:0] bv  [7] = '{32'h2, 32'hFFFFFFFF, 32'h0, 32'hA, 32'hFFFFFFF9, 32'h0, 32'h0000_0007};
    exp_t e; int lat; bit seen;
    for (int i = 0; i < 7; i++) begin
      drive_start(ops[i], av[i], bv[i], {$urandom, $urandom});
      wait_done(lat, seen);
      e = sb_q.pop_front();
      checks++;
      if (!seen || lat != e.lat) begin failures++; $display("FAIL div_latency[%0d] got %0d exp %0d", i, lat, e.lat); end
      checks++;
      if ({hi_o, lo_o, div0_o} !== {e.hi, e.lo, e.div0}) begin
        failures++;
        $display("FAIL div_result[%0d] got hi=%h lo=%h div0=%b exp hi=%h lo=%h div0=%b", i, hi_o, lo_o, div0_o, e.hi, e.lo, e.div0);
      end
      last_exp = e;
    end
  endtask

  // Random op mix, each start issued in the DONE cycle of the previous op.
  task automatic test_back_to_back();
    exp_t e; int lat; bit seen;
    logic [W-1:0] b;
    for (int i = 0; i < 10; i++) begin
      b = (i == 3) ? '0 : W'($urandom);
      drive_start(3'($urandom_range(0, 7)), W'($urandom), b, {$urandom, $urandom});
      wait_done(lat, seen);
      e = sb_q.pop_front();
      checks++;
      if (!seen || lat != e.lat) begin failures++; $display("FAIL b2b_latency[%0d] got %0d exp %0d", i, lat, e.lat); end
      checks++;
      if ({hi_o, lo_o, div0_o} !== {e.hi, e.lo, e.div0}) begin
        failures++;
        $display("FAIL b2b_result[%0d] got hi=%h lo=%h div0=%b exp hi=%h lo=%h div0=%b", i, hi_o, lo_o, div0_o, e.hi, e.lo, e.div0);
      end
      last_exp = e;
    end
  endtask

  task automatic test_cancel();
    exp_t e; int lat; bit seen;
    // DIVU in flight, cancelled in cycle N+10 (not queued: it must never complete).
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL cancel_busy got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL cancel_done got %b exp 0", done_o); end
    checks++;
    if ({hi_o, lo_o, div0_o} !== {last_exp.hi, last_exp.lo, last_exp.div0}) begin
      failures++;
      $display("FAIL cancel_hold got hi=%h lo=%h div0=%b exp hi=%h lo=%h div0=%b", hi_o, lo_o, div0_o, last_exp.hi, last_exp.lo, last_exp.div0);
    end
    drive_start(OP_DIVU, 32'd1000, 32'd9, '0);
    wait_done(lat, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || lat != e.lat) begin failures++; $display("FAIL cancel_restart_latency got %0d exp %0d", lat, e.lat); end
    checks++;
    if ({hi_o, lo_o, div0_o} !== {e.hi, e.lo, e.div0}) begin
      failures++;
      $display("FAIL cancel_restart_result got hi=%h lo=%h exp hi=%h lo=%h", hi_o, lo_o, e.hi, e.lo);
    end
    last_exp = e;
    // Cancel wins over a simultaneous start.
    start_i = 1'b1; cancel_i = 1'b1; op_i = OP_MULT; a_i = 32'd3; b_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL cancel_beats_start_busy got %b exp 0", busy_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL cancel_beats_start_done got %b exp 0", done_o); end
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd3; b_i = 32'd10;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rstmid_done got %b exp 0", done_o); end
    checks++;
    if ({hi_o, lo_o, div0_o} !== {W'(0), W'(0), 1'b0}) begin
      failures++;
      $display("FAIL rstmid_outputs got hi=%h lo=%h div0=%b exp 0", hi_o, lo_o, div0_o);
    end
    rst = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_stays_idle got busy=%b done=%b exp 0", busy_o, done_o); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_acc();
    test_div();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
